// File: rtl/ras_ckpt_buffer.sv
// ras_ckpt_buffer
//   Checkpoint buffer for the return address stack. Every predicted
//   control-flow instruction captures a RAS snapshot ({sp, top two entries})
//   into a circular buffer and gets a tag. Commits free checkpoints from the
//   head. A mispredict restores the RAS from the tagged checkpoint and
//   discards every younger checkpoint.
//
//   Optional feature macro: RAS_CKPT_CHECK_EN
//     defined   - mispredict tags are liveness-checked; overflow, underflow
//                 and non-live mispredicts set the sticky ckpt_err flag.
//     undefined - every mispredict is restored, ckpt_err is tied to 0.
//
// Ports
//   CLK, reset_n        clock, asynchronous active-low reset
//   ckpt_alloc          capture {sp_snap, ras_snap} into a new checkpoint
//   sp_snap, ras_snap   RAS snapshot to capture ({RAS[sp-2], RAS[sp-1]})
//   ckpt_id             tag for an allocation this cycle (== tail)
//   ckpt_full/empty     occupancy flags from the registered count
//   commit_free         oldest checkpoint committed; free the head
//   mispredict(_id)     branch with this tag resolved as mispredicted
//   restore_ras         one-cycle restore pulse to the RAS
//   rb_sp_snap/ras_snap restored snapshot, held between restores
//   ckpt_err            sticky protocol-error flag
module ras_ckpt_buffer #(
    parameter int RAS_ADDRESS  = 3,
    parameter int XLEN         = 32,
    parameter int CKPT_ADDRESS = 3
) (
    input  logic                    CLK,
    input  logic                    reset_n,
    input  logic                    ckpt_alloc,
    input  logic [RAS_ADDRESS-1:0]  sp_snap,
    input  logic [2*XLEN-1:0]       ras_snap,
    output logic [CKPT_ADDRESS-1:0] ckpt_id,
    output logic                    ckpt_full,
    output logic                    ckpt_empty,
    input  logic                    commit_free,
    input  logic                    mispredict,
    input  logic [CKPT_ADDRESS-1:0] mispredict_id,
    output logic                    restore_ras,
    output logic [RAS_ADDRESS-1:0]  rb_sp_snap,
    output logic [2*XLEN-1:0]       rb_ras_snap,
    output logic                    ckpt_err
);

    localparam int CKPT_LEN = 1 << CKPT_ADDRESS;
    localparam int ENTRY_W  = RAS_ADDRESS + 2*XLEN;

    typedef logic [CKPT_ADDRESS-1:0] ptr_t;
    typedef logic [CKPT_ADDRESS:0]   cnt_t;

    ptr_t               head, tail;
    cnt_t               count;
    logic [ENTRY_W-1:0] mem [CKPT_LEN];

    ptr_t head_nx, tail_nx;
    cnt_t count_nx;
    ptr_t mp_offset;
    logic mp_live;
    logic alloc_ok, free_ok, mp_ok;

    assign ckpt_full  = (count == cnt_t'(CKPT_LEN));
    assign ckpt_empty = (count == '0);
    assign ckpt_id    = tail;

    // Distance of the mispredicted tag from the head; wraps naturally in
    // CKPT_ADDRESS bits, so it is the age rank of that checkpoint.
    assign mp_offset = mispredict_id - head;

`ifdef RAS_CKPT_CHECK_EN
    assign mp_live = ({1'b0, mp_offset} < count);
`else
    assign mp_live = 1'b1;
`endif

    // A mispredict makes any same-cycle allocation wrong-path.
    assign alloc_ok = ckpt_alloc && !ckpt_full && !mispredict;
    assign free_ok  = commit_free && !ckpt_empty;
    assign mp_ok    = mispredict && mp_live;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        head_nx  = head;
        tail_nx  = tail;
        count_nx = count;
        if (free_ok) head_nx = head + ptr_t'(1);
        if (mp_ok) begin
            // Keep the mispredicted checkpoint and everything older; the
            // head advance of a same-cycle commit is taken off the top.
            tail_nx  = mispredict_id + ptr_t'(1);
            count_nx = cnt_t'({1'b0, mp_offset}) + cnt_t'(1) - cnt_t'(free_ok);
        end else begin
            if (alloc_ok) tail_nx = tail + ptr_t'(1);
            count_nx = count + cnt_t'(alloc_ok) - cnt_t'(free_ok);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            restore_ras <= 1'b0;
            rb_sp_snap  <= '0;
            rb_ras_snap <= '0;
        end else begin
            head        <= head_nx;
            tail        <= tail_nx;
            count       <= count_nx;
            restore_ras <= mp_ok;
            if (mp_ok) {rb_sp_snap, rb_ras_snap} <= mem[mispredict_id];
        end
    end

    // NOTE: the snapshot storage has no reset; an entry is only ever read
    // after it was written by an allocation, so its power-up value is unused.
    always_ff @(posedge CLK) begin
        if (alloc_ok) mem[tail] <= {sp_snap, ras_snap};
    end

`ifdef RAS_CKPT_CHECK_EN
    logic err_q;
    logic err_event;

    assign err_event = (ckpt_alloc && ckpt_full && !mispredict)
                     || (commit_free && ckpt_empty)
                     || (mispredict && !mp_live);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else if (err_event) err_q <= 1'b1;
    end

    assign ckpt_err = err_q;
`else
    assign ckpt_err = 1'b0;
`endif

endmodule

// File: tb/tb_ras_ckpt_buffer.sv
// tb_ras_ckpt_buffer
//   Directed scenarios with hand-computed expectations, followed by random
//   traffic. A queue-based reference model of the live checkpoints runs
//   alongside; a compare process checks every DUT output against it on each
//   falling clock edge.
module tb_ras_ckpt_buffer;

    localparam int RAS_ADDRESS  = 3;
    localparam int XLEN         = 32;
    localparam int CKPT_ADDRESS = 3;
    localparam int CKPT_LEN     = 1 << CKPT_ADDRESS;

`ifdef RAS_CKPT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                    CLK = 1'b0;
    logic                    reset_n;
    logic                    ckpt_alloc;
    logic [RAS_ADDRESS-1:0]  sp_snap;
    logic [2*XLEN-1:0]       ras_snap;
    logic [CKPT_ADDRESS-1:0] ckpt_id;
    logic                    ckpt_full, ckpt_empty;
    logic                    commit_free;
    logic                    mispredict;
    logic [CKPT_ADDRESS-1:0] mispredict_id;
    logic                    restore_ras;
    logic [RAS_ADDRESS-1:0]  rb_sp_snap;
    logic [2*XLEN-1:0]       rb_ras_snap;
    logic                    ckpt_err;

    ras_ckpt_buffer #(
        .RAS_ADDRESS (RAS_ADDRESS),
        .XLEN        (XLEN),
        .CKPT_ADDRESS(CKPT_ADDRESS)
    ) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .ckpt_alloc   (ckpt_alloc),
        .sp_snap      (sp_snap),
        .ras_snap     (ras_snap),
        .ckpt_id      (ckpt_id),
        .ckpt_full    (ckpt_full),
        .ckpt_empty   (ckpt_empty),
        .commit_free  (commit_free),
        .mispredict   (mispredict),
        .mispredict_id(mispredict_id),
        .restore_ras  (restore_ras),
        .rb_sp_snap   (rb_sp_snap),
        .rb_ras_snap  (rb_ras_snap),
        .ckpt_err     (ckpt_err)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                     tag;
        logic [RAS_ADDRESS-1:0] sp;
        logic [2*XLEN-1:0]      ras;
    } ent_t;

    ent_t                   live_q[$];   // live checkpoints, oldest first
    int                     m_tail;      // next tag to hand out
    logic                   m_restore;
    logic [RAS_ADDRESS-1:0] m_sp;
    logic [2*XLEN-1:0]      m_ras;
    logic                   m_err;

    function automatic int find_live(input int tag);
        for (int i = 0; i < live_q.size(); i++)
            if (live_q[i].tag == tag) return i;
        return -1;
    endfunction

    always @(posedge CLK or negedge reset_n) begin
        int   idx;
        int   sz0;
        ent_t e;
        if (!reset_n) begin
            live_q.delete();
            m_tail    = 0;
            m_restore = 1'b0;
            m_sp      = '0;
            m_ras     = '0;
            m_err     = 1'b0;
        end else begin
            m_restore = 1'b0;
            sz0       = live_q.size();
            if (mispredict) begin
                idx = find_live(int'(mispredict_id));
                if (idx >= 0) begin
                    m_restore = 1'b1;
                    m_sp      = live_q[idx].sp;
                    m_ras     = live_q[idx].ras;
                    while (live_q.size() > idx + 1) void'(live_q.pop_back());
                    m_tail = (int'(mispredict_id) + 1) % CKPT_LEN;
                    if (commit_free) void'(live_q.pop_front());
                end else if (CHK) begin
                    m_err = 1'b1;
                end
            end else begin
                if (commit_free) begin
                    if (sz0 > 0) void'(live_q.pop_front());
                    else if (CHK) m_err = 1'b1;
                end
                if (ckpt_alloc) begin
                    if (sz0 == CKPT_LEN) begin
                        if (CHK) m_err = 1'b1;
                    end else begin
                        e.tag = m_tail;
                        e.sp  = sp_snap;
                        e.ras = ras_snap;
                        live_q.push_back(e);
                        m_tail = (m_tail + 1) % CKPT_LEN;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        check("ckpt_id",     64'(ckpt_id),     64'(m_tail));
        check("ckpt_full",   64'(ckpt_full),   64'(live_q.size() == CKPT_LEN));
        check("ckpt_empty",  64'(ckpt_empty),  64'(live_q.size() == 0));
        check("restore_ras", 64'(restore_ras), 64'(m_restore));
        check("rb_sp_snap",  64'(rb_sp_snap),  64'(m_sp));
        check("rb_ras_snap", 64'(rb_ras_snap), 64'(m_ras));
        check("ckpt_err",    64'(ckpt_err),    64'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ckpt_alloc  = 1'b0;
        commit_free = 1'b0;
        mispredict  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic alloc(input int sp, input logic [63:0] ras);
        idle();
        ckpt_alloc = 1'b1;
        sp_snap    = RAS_ADDRESS'(sp);
        ras_snap   = ras;
        tick();
        idle();
    endtask

    task automatic free_n(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            commit_free = 1'b1;
            tick();
        end
        idle();
    endtask

    initial begin
        reset_n       = 1'b0;
        sp_snap       = '0;
        ras_snap      = '0;
        mispredict_id = '0;
        idle();
        tick();
        // Reset state.
        check("rst_empty", 64'(ckpt_empty), 64'd1);
        check("rst_full",  64'(ckpt_full),  64'd0);
        check("rst_id",    64'(ckpt_id),    64'd0);
        check("rst_rest",  64'(restore_ras), 64'd0);
        check("rst_err",   64'(ckpt_err),   64'd0);
        do_reset();

        // Three allocations: tags 0,1,2 handed out in order.
        for (int i = 0; i < 3; i++) begin
            idle();
            ckpt_alloc = 1'b1;
            sp_snap    = RAS_ADDRESS'(i + 1);
            ras_snap   = 64'h1000_0000_0000_0000 + 64'(i);
            check("alloc_id", 64'(ckpt_id), 64'(i));
            tick();
        end
        idle();
        check("a3_id",    64'(ckpt_id),    64'd3);
        check("a3_empty", 64'(ckpt_empty), 64'd0);

        // Allocations 3,4, then mispredict on tag 2 with a wrong-path alloc.
        alloc(4, 64'h1000_0000_0000_0003);
        alloc(5, 64'h1000_0000_0000_0004);
        mispredict    = 1'b1;
        mispredict_id = 3'd2;
        ckpt_alloc    = 1'b1;
        sp_snap       = 3'd7;
        ras_snap      = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        idle();
        check("mp_restore", 64'(restore_ras), 64'd1);
        check("mp_sp",      64'(rb_sp_snap),  64'd3);
        check("mp_ras",     64'(rb_ras_snap), 64'h1000_0000_0000_0002);
        check("mp_id",      64'(ckpt_id),     64'd3);
        tick();
        check("mp_pulse",   64'(restore_ras), 64'd0);
        check("mp_hold",    64'(rb_sp_snap),  64'd3);
        // Three live checkpoints remain: three frees empty the buffer.
        free_n(2);
        check("f2_empty", 64'(ckpt_empty), 64'd0);
        free_n(1);
        check("f3_empty", 64'(ckpt_empty), 64'd1);
        free_n(1);  // underflow: ignored
        check("uf_err",   64'(ckpt_err),   64'(CHK));
        check("uf_empty", 64'(ckpt_empty), 64'd1);

        // Fill from tail 3: eight allocations, the ninth is dropped.
        for (int i = 0; i < CKPT_LEN; i++) alloc(i, 64'h2000_0000_0000_0000 + 64'(i));
        check("full",     64'(ckpt_full), 64'd1);
        check("full_id",  64'(ckpt_id),   64'd3);
        alloc(1, 64'h2000_0000_0000_00FF);
        check("of_full",  64'(ckpt_full), 64'd1);
        check("of_id",    64'(ckpt_id),   64'd3);
        check("of_err",   64'(ckpt_err),  64'(CHK));
        // Alloc plus free while full: the alloc is still dropped.
        ckpt_alloc  = 1'b1;
        commit_free = 1'b1;
        tick();
        idle();
        check("af_full",  64'(ckpt_full), 64'd0);
        check("af_id",    64'(ckpt_id),   64'd3);

        // Reset during a pending restore (tag 4 is live).
        mispredict    = 1'b1;
        mispredict_id = 3'd4;
        #3 reset_n = 1'b0;
        tick();
        check("rr_rest",  64'(restore_ras), 64'd0);
        check("rr_id",    64'(ckpt_id),     64'd0);
        check("rr_empty", 64'(ckpt_empty),  64'd1);
        check("rr_err",   64'(ckpt_err),    64'd0);
        idle();
        tick();
        reset_n = 1'b1;

        // Wrap: move head/tail to 7, then live tags 7,0,1.
        for (int i = 0; i < 7; i++) alloc(0, 64'(i));
        free_n(7);
        check("w_id7", 64'(ckpt_id), 64'd7);
        alloc(1, 64'h3000_0000_0000_0007);
        alloc(2, 64'h3000_0000_0000_0000);
        alloc(3, 64'h3000_0000_0000_0001);
        mispredict    = 1'b1;
        mispredict_id = 3'd0;
        commit_free   = 1'b1;
        tick();
        idle();
        check("w_rest",  64'(restore_ras), 64'd1);
        check("w_sp",    64'(rb_sp_snap),  64'd2);
        check("w_ras",   64'(rb_ras_snap), 64'h3000_0000_0000_0000);
        check("w_id",    64'(ckpt_id),     64'd1);
        check("w_empty", 64'(ckpt_empty),  64'd0);
        free_n(1);  // count was 1
        check("w_empty2", 64'(ckpt_empty), 64'd1);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            ckpt_alloc  = 1'($urandom_range(0, 1));
            commit_free = ($urandom_range(0, 9) < 4);
            sp_snap     = RAS_ADDRESS'($urandom);
            ras_snap    = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 5) == 0 && live_q.size() > 0) begin
                mispredict    = 1'b1;
                mispredict_id = CKPT_ADDRESS'(live_q[$urandom_range(0, live_q.size() - 1)].tag);
                if (CHK && $urandom_range(0, 3) == 0) begin
                    mispredict_id = CKPT_ADDRESS'($urandom);
                    if (find_live(int'(mispredict_id)) < 0) commit_free = 1'b0;
                end
            end
            if (cyc % 997 == 500) begin
                #2 reset_n = 1'b0;
                tick();
                idle();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end
        idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
